// File: rtl/map_bg_pkg.sv
// Shared constants, colour struct and fetch FSM states for the map background path.
// Pure declarations; no timing or flow control of its own.
package map_bg_pkg;

    localparam int MAP_W       = 320;
    localparam int MAP_H       = 240;
    localparam int SCALE_SHIFT = 1;
    localparam int IDX_W       = 3;
    localparam int ADDR_W      = 17;

    localparam int X_W         = 10;
    localparam int Y_W         = 10;
    localparam int SCROLL_W    = 9;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // scroll_x never reaches 2*MAP_W, so a single conditional subtract is an exact mod
    function automatic logic [SCROLL_W-1:0] scroll_mod(input logic [SCROLL_W-1:0] s);
        return (s >= SCROLL_W'(MAP_W)) ? s - SCROLL_W'(MAP_W) : s;
    endfunction

endpackage

// File: rtl/map_bg_addr_gen.sv
// Screen-to-map address: downscale, horizontal scroll with wrap, row multiply.
// Purely combinational; zero latency, no flow control.
module map_bg_addr_gen
    import map_bg_pkg::*;
(
    input  logic [X_W-1:0]      draw_x_i,
    input  logic [Y_W-1:0]      draw_y_i,
    input  logic [SCROLL_W-1:0] scroll_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                y_oob_o
);

    localparam int MX_W = X_W + 1;

    logic [MX_W-1:0] mx_sum;
    logic [MX_W-1:0] mx_wrap;
    logic [Y_W-1:0]  my;

    always_comb begin
        // Full-width sum so the wrap compare sees the untruncated value
        mx_sum  = MX_W'(draw_x_i >> SCALE_SHIFT) + MX_W'(scroll_i);
        mx_wrap = (mx_sum >= MX_W'(MAP_W)) ? mx_sum - MX_W'(MAP_W) : mx_sum;
        my      = draw_y_i >> SCALE_SHIFT;
        y_oob_o = (my >= Y_W'(MAP_H));
        addr_o  = ADDR_W'(my) * ADDR_W'(MAP_W) + ADDR_W'(mx_wrap);
    end

endmodule

// File: rtl/map_bg_fetch_ctrl.sv
// Per-pixel background fetch: coords -> ROM address -> palette -> registered RGB.
// Two-cycle latency, one pixel per clock, no backpressure (pix_en is never stalled).
module map_bg_fetch_ctrl
    import map_bg_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                pix_en,
    input  logic [X_W-1:0]      DrawX,
    input  logic [Y_W-1:0]      DrawY,
    input  logic                vid_on,
    input  logic                frame_start,
    input  logic [SCROLL_W-1:0] scroll_x,
    output logic                rom_rd,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [IDX_W-1:0]    rom_data,
    output logic [IDX_W-1:0]    pal_index,
    input  logic [3:0]          pal_red,
    input  logic [3:0]          pal_green,
    input  logic [3:0]          pal_blue,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                pix_valid
);

    fetch_state_t        state_q;
    logic [SCROLL_W-1:0] scroll_q;
    logic [SCROLL_W-1:0] scroll_d;
    logic                rom_rd_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [ADDR_W-1:0]   rom_addr_d;
    logic                v1_q;
    logic                b1_q;
    logic                black0_d;
    logic                y_oob;
    rgb_t                rgb_q;
    rgb_t                pal_rgb;
    logic                pix_valid_q;

    map_bg_addr_gen u_addr_gen (
        .draw_x_i (DrawX),
        .draw_y_i (DrawY),
        .scroll_i (scroll_q),
        .addr_o   (rom_addr_d),
        .y_oob_o  (y_oob)
    );

    assign scroll_d = scroll_mod(scroll_x);
    assign black0_d = ~vid_on | y_oob | (state_q == SYNC);
    assign pal_rgb  = '{r: pal_red, g: pal_green, b: pal_blue};

    // A pixel coinciding with frame_start still sees the old scroll_q
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= SYNC;
            scroll_q    <= '0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            v1_q        <= 1'b0;
            b1_q        <= 1'b0;
            rgb_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            if (frame_start) begin
                state_q  <= RUN;
                scroll_q <= scroll_d;
            end
            rom_rd_q <= pix_en & ~black0_d;
            if (pix_en) begin
                rom_addr_q <= rom_addr_d;
            end
            v1_q <= pix_en;
            b1_q <= black0_d;
            if (v1_q) begin
                rgb_q <= b1_q ? '0 : pal_rgb;
            end
            pix_valid_q <= v1_q;
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign pal_index = rom_data;
    assign red       = rgb_q.r;
    assign green     = rgb_q.g;
    assign blue      = rgb_q.b;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_map_bg_fetch_ctrl.sv
// Bench for map_bg_fetch_ctrl: pixel-queue reference model plus directed literal checks.
module tb_map_bg_fetch_ctrl;
    import map_bg_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        vid_on;
    logic        frame_start;
    logic [8:0]  scroll_x;
    logic        rom_rd;
    logic [16:0] rom_addr;
    logic [2:0]  rom_data;
    logic [2:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  red, green, blue;
    logic        pix_valid;

    int n_tests = 0;
    int n_fail  = 0;

    map_bg_fetch_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .vid_on      (vid_on),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pal_index   (pal_index),
        .pal_red     (pal_red),
        .pal_green   (pal_green),
        .pal_blue    (pal_blue),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pix_valid   (pix_valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2:0] rom_fn(input logic [16:0] a);
        return a[2:0];
    endfunction

    // packed {r,g,b}; index 2 -> 12'h144
    function automatic logic [11:0] pal_fn(input logic [2:0] i);
        logic [3:0] r, g, b;
        r = 4'(i >> 1);
        g = {i, 1'b0};
        b = 4'(i) + 4'd2;
        return {r, g, b};
    endfunction

    // Junk value when no read is issued so a missing rom_rd shows up in the colour
    assign rom_data = rom_rd ? rom_fn(rom_addr) : 3'd5;
    assign {pal_red, pal_green, pal_blue} = pal_fn(pal_index);

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } pend_t;

    pend_t       pq[$];
    int          edge_n = 0;
    bit          m_run;
    int          m_scroll;
    bit          e_pv;
    bit          e_rd;
    int          e_addr;
    logic [11:0] e_rgb;
    bit          chk_en = 1'b0;
    int          pv_cnt = 0;

    task automatic model_edge();
        int mx, my, addr;
        bit black;
        pend_t p;
        edge_n++;
        if (Reset) begin
            pq.delete();
            m_run = 0; m_scroll = 0;
            e_pv = 0; e_rd = 0; e_addr = 0; e_rgb = 12'h0;
            return;
        end
        e_pv = 0;
        if (pq.size() > 0 && pq[0].due == edge_n) begin
            p = pq.pop_front();
            e_pv  = 1;
            e_rgb = p.rgb;
        end
        mx    = (int'(DrawX) / 2 + m_scroll) % MAP_W;
        my    = int'(DrawY) / 2;
        addr  = my * MAP_W + mx;
        black = !vid_on || my >= MAP_H || !m_run;
        e_rd  = pix_en && !black;
        if (pix_en) begin
            e_addr = addr;
            p.due  = edge_n + 1;
            p.rgb  = black ? 12'h0 : pal_fn(rom_fn(17'(addr)));
            pq.push_back(p);
        end
        if (frame_start) begin
            m_run    = 1;
            m_scroll = int'(scroll_x) % MAP_W;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("pix_valid", 32'(pix_valid), 32'(e_pv));
            chk("rom_rd", 32'(rom_rd), 32'(e_rd));
            chk("rom_addr", 32'(rom_addr), 32'(e_addr));
            chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
            if (e_rd) chk("pal_index", 32'(pal_index), 32'(rom_fn(17'(e_addr))));
            if (pix_valid) pv_cnt++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input bit en, input int x, input int y, input bit vo,
                         input bit fs, input int sx);
        pix_en      = en;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        vid_on      = vo;
        frame_start = fs;
        scroll_x    = 9'(sx);
    endtask

    task automatic idle();
        pix_en      = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        Reset = 1'b0;

        // SYNC: pixel still flows, but black and no read
        drive(1, 100, 50, 1, 0, 0);
        tick();
        chk("sync_rom_rd", 32'(rom_rd), 32'd0);
        idle();
        tick();
        chk("sync_pix_valid", 32'(pix_valid), 32'd1);
        chk("sync_rgb", 32'({red, green, blue}), 32'd0);

        // RUN with scroll 0
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 100, 50, 1, 0, 0);
        tick();
        chk("addr_8050", 32'(rom_addr), 32'd8050);
        chk("rd_8050", 32'(rom_rd), 32'd1);
        chk("pal_idx_2", 32'(pal_index), 32'd2);
        idle();
        tick();
        chk("rgb_144", 32'({red, green, blue}), 32'h144);
        chk("pv_8050", 32'(pix_valid), 32'd1);

        // scroll 300 wraps
        drive(0, 0, 0, 1, 1, 300);
        tick();
        drive(1, 100, 50, 1, 0, 300);
        tick();
        chk("addr_8030", 32'(rom_addr), 32'd8030);
        idle();
        tick();
        chk("rgb_8030", 32'({red, green, blue}), 32'h3C8);

        // scroll 511 at the bottom-right corner
        drive(0, 0, 0, 1, 1, 511);
        tick();
        drive(1, 639, 479, 1, 0, 511);
        tick();
        chk("addr_76670", 32'(rom_addr), 32'd76670);
        idle();
        tick();

        // scroll_x moves without frame_start: latched value stays
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 100, 50, 1, 0, 200);
        tick();
        chk("addr_no_relatch", 32'(rom_addr), 32'd8050);
        idle();
        tick();

        // one full line back-to-back
        drive(0, 0, 0, 1, 1, 0);
        tick();
        pv_cnt = 0;
        for (int x = 0; x < 640; x++) begin
            drive(1, x, 0, 1, 0, 0);
            tick();
        end
        idle();
        tick();
        tick();
        chk("line_pv_count", 32'(pv_cnt), 32'd640);
        chk("line_last_addr", 32'(rom_addr), 32'd319);

        // blanking pixel
        drive(1, 100, 50, 0, 0, 0);
        tick();
        chk("blank_rom_rd", 32'(rom_rd), 32'd0);
        idle();
        tick();
        chk("blank_pv", 32'(pix_valid), 32'd1);
        chk("blank_rgb", 32'({red, green, blue}), 32'd0);

        // Reset one cycle after a pixel
        drive(1, 100, 50, 1, 0, 0);
        tick();
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_mid_pv", 32'(pix_valid), 32'd0);
        chk("rst_mid_rd", 32'(rom_rd), 32'd0);
        chk("rst_mid_addr", 32'(rom_addr), 32'd0);
        tick();
        chk("rst_mid_pv2", 32'(pix_valid), 32'd0);
        drive(1, 100, 50, 1, 0, 0);
        tick();
        chk("post_rst_rd", 32'(rom_rd), 32'd0);
        idle();
        tick();
        chk("post_rst_pv", 32'(pix_valid), 32'd1);
        chk("post_rst_rgb", 32'({red, green, blue}), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(399) == 0);
            drive(($urandom_range(3) != 0), int'($urandom_range(639)), int'($urandom_range(511)),
                  ($urandom_range(7) != 0), ($urandom_range(99) == 0), int'($urandom_range(511)));
            tick();
        end
        Reset = 1'b0;
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/map_bg_fetch_ctrl.md
Name: map_bg_fetch_ctrl

Overview:
- Sequences per-pixel background rendering: converts VGA draw coordinates into a map ROM address, issues the ROM read, feeds the returned colour index to the background palette, and registers the final RGB.
- Adds horizontal scroll with wrap-around; the scroll value is latched once per frame.
- Sits between vga_controller/color_mapper timing and the map ROM + map_background_palette pair.
- Fully pipelined: one pixel per Clk at full rate.

Parameters:
- MAP_W, 320, map width in map pixels
- MAP_H, 240, map height in map pixels
- SCALE_SHIFT, 1, screen-to-map downscale (screen coordinate >> SCALE_SHIFT)
- IDX_W, 3, palette index width
- ADDR_W, 17, ROM address width (must hold MAP_W*MAP_H-1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- pix_en  in  1  one-cycle strobe: DrawX/DrawY/vid_on valid for a new pixel
- DrawX  in  10  screen x, 0..639
- DrawY  in  10  screen y, 0..479
- vid_on  in  1  1 = active video; 0 = blanking
- frame_start  in  1  one-cycle strobe at the start of each frame
- scroll_x  in  9  requested horizontal scroll in map pixels
- rom_rd  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  IDX_W  ROM index; valid exactly 1 Clk after rom_rd
- pal_index  out  IDX_W  index to map_background_palette (combinational path to the palette)
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index
- red, green, blue  out  4 each  registered pixel colour
- pix_valid  out  1  red/green/blue correspond to the pixel accepted 2 cycles earlier

Behaviour:
- Reset values:
  - rom_rd=0, rom_addr=0, red/green/blue=0, pix_valid=0
  - scroll_q=0, all pipeline valid and black flags=0
  - FSM=SYNC
- FSM SYNC:
  - Each pix_en still produces pix_valid 2 cycles later, with RGB=0.
  - No ROM reads are issued.
  - frame_start transitions to RUN.
- FSM RUN: normal rendering. Stays in RUN until Reset.
- Scroll latch:
  - On frame_start (either state): scroll_q <= scroll_x mod MAP_W.
  - Because scroll_x < 2*MAP_W, one conditional subtract performs the mod.
  - scroll_x changes between frame_starts are ignored.
- Stage 0 (cycle of pix_en):
  - mx = (DrawX>>SCALE_SHIFT) + scroll_q. If mx >= MAP_W, subtract MAP_W; the sum is < 2*MAP_W, so this wrap is exact.
  - my = DrawY>>SCALE_SHIFT.
  - black0 = !vid_on | (my >= MAP_H) | (state==SYNC).
  - Registers: rom_addr <= my*MAP_W + mx; rom_rd <= pix_en & !black0; v1 <= pix_en; b1 <= black0.
  - rom_addr holds its last value when pix_en=0.
  - If frame_start and pix_en coincide, the pixel uses the old scroll_q.
- Stage 1:
  - pal_index = rom_data (combinational).
  - Registers: red/green/blue <= b1 ? 0 : pal_*; pix_valid <= v1.
  - When v1=0, RGB holds its previous value.
- Latency: pix_en at cycle N gives pix_valid=1 and RGB at cycle N+2. Back-to-back pix_en each cycle is supported with no bubbles.
- Arithmetic widths:
  - my*MAP_W is computed at ADDR_W bits; the product fits for the defaults (239*320+319 = 76799 < 2^17).
  - No truncation of mx before the wrap compare.
- Mid-operation Reset: clears the pipeline in the same edge, with no stale pix_valid afterwards. FSM returns to SYNC and requires a new frame_start before rendering.

Decomposition:
- Shared package map_bg_pkg holds:
  - MAP_W, MAP_H, SCALE_SHIFT, IDX_W, ADDR_W constants
  - typedef rgb_t: packed struct of 4-bit r, g, b
  - typedef enum fetch_state_t {SYNC, RUN}
- One natural sub-module: map_bg_addr_gen, the combinational scroll-wrap and address multiply. It is kept separate so it can be unit-tested on its own.
- The palette and ROM stay external.

Test Plan:
- Reset, then pix_en with DrawX=100, DrawY=50, vid_on=1, no frame_start -> pix_valid at +2, RGB=0, rom_rd never 1 (SYNC).
- frame_start with scroll_x=0, then pix_en DrawX=100, DrawY=50 -> rom_addr=8050, rom_rd=1 next cycle. ROM model returns 2 -> pal_index=2; palette gives {1,4,4} -> RGB={1,4,4} at +2.
- frame_start with scroll_x=300, then DrawX=100, DrawY=50 -> mx=350-320=30, rom_addr=8030. frame_start with scroll_x=511, then DrawX=639, DrawY=479 -> mx=510-320=190, rom_addr=239*320+190=76670.
- 640 consecutive pix_en (one line, DrawY=0, scroll_x=0) -> 640 consecutive pix_valid pulses, no gaps. Addresses step by 1 every 2 pixels.
- Blanking and scroll timing:
  - vid_on=0 with pix_en -> rom_rd=0, RGB=0, pix_valid=1 at +2.
  - scroll_x changed mid-frame without frame_start -> addresses unchanged.
- Reset asserted one cycle after pix_en -> pix_valid stays 0 and outputs return to reset values. The next pixel before a frame_start renders black.
